// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer
//
// Purpose: buffers ALU commands in a small FIFO, issues them one at a time
// to a registered 4-bit ALU, captures each result and hands it downstream.
// Results leave in command order; op 00 commands are silently dropped.
//
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-high reset
//   cmd_valid/cmd_ready      command handshake (ready while FIFO not full)
//   cmd_x, cmd_y, cmd_op     operands and opcode (00 drop, 01 add, 10 sub, 11 nop)
//   input_x, input_y         registered operands to the ALU
//   control_signal           registered opcode to the ALU (00 when idle)
//   output_result            ALU result, one cycle after the pins are driven
//   res_valid/res_ready      result handshake
//   res_data                 captured ALU result
//   fifo_count               number of queued commands
//   ops_done                 (only with ALU_SEQ_STATS_EN) 8-bit wrapping count
//                            of completed result handshakes
//
// Optional feature macro: ALU_SEQ_STATS_EN
module alu_cmd_sequencer #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [WIDTH-1:0]       cmd_x,
  input  logic [WIDTH-1:0]       cmd_y,
  input  logic [1:0]             cmd_op,
  output logic [WIDTH-1:0]       input_x,
  output logic [WIDTH-1:0]       input_y,
  output logic [1:0]             control_signal,
  input  logic [WIDTH-1:0]       output_result,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [WIDTH-1:0]       res_data,
  output logic [$clog2(DEPTH):0] fifo_count
`ifdef ALU_SEQ_STATS_EN
  ,
  output logic [7:0]             ops_done
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = 2 * WIDTH + 2;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_CAPTURE,
    S_HOLD
  } state_t;

  // ---------------------------------------------------------------------
  // Command FIFO
  // ---------------------------------------------------------------------
  logic [EW-1:0]    fifo_mem [DEPTH];
  logic [PW-1:0]    wr_ptr_reg;
  logic [PW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             push;
  logic             pop;
  logic             fifo_empty;
  logic [WIDTH-1:0] head_x;
  logic [WIDTH-1:0] head_y;
  logic [1:0]       head_op;

  // Ready is a pure function of the registered count: no look-ahead at a
  // same-cycle pop, so a full FIFO stays not-ready even while popping.
  assign cmd_ready  = (count_reg < DEPTH_C);
  assign fifo_empty = (count_reg == '0);
  assign push       = cmd_valid && cmd_ready;
  assign fifo_count = count_reg;

  // The head entry is read combinationally so the FSM can act on a pop in
  // the same cycle it is decided (needed for the one-cycle IDLE->ISSUE hop).
  assign {head_op, head_y, head_x} = fifo_mem[rd_ptr_reg];

  // Storage needs no reset: entries are only read when count_reg says valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= {cmd_op, cmd_y, cmd_x};
    end
  end

  // Pointers are PW bits wide, so DEPTH being a power of two gives the
  // modulo-DEPTH wrap for free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Issue / capture FSM
  // ---------------------------------------------------------------------
  state_t           state_reg, state_next;
  logic [WIDTH-1:0] x_reg, x_next;
  logic [WIDTH-1:0] y_reg, y_next;
  logic [1:0]       ctrl_reg, ctrl_next;
  logic             res_valid_reg, res_valid_next;
  logic [WIDTH-1:0] res_data_reg, res_data_next;

  assign input_x        = x_reg;
  assign input_y        = y_reg;
  assign control_signal = ctrl_reg;
  assign res_valid      = res_valid_reg;
  assign res_data       = res_data_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      x_reg         <= '0;
      y_reg         <= '0;
      ctrl_reg      <= 2'b00;
      res_valid_reg <= 1'b0;
      res_data_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      x_reg         <= x_next;
      y_reg         <= y_next;
      ctrl_reg      <= ctrl_next;
      res_valid_reg <= res_valid_next;
      res_data_reg  <= res_data_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    x_next         = x_reg;
    y_next         = y_reg;
    ctrl_next      = ctrl_reg;
    res_valid_next = res_valid_reg;
    res_data_next  = res_data_reg;
    pop            = 1'b0;

    case (state_reg)
      S_IDLE: begin
        ctrl_next = 2'b00;
        if (!fifo_empty) begin
          pop = 1'b1;
          // Op 00 is consumed here and never reaches the ALU pins.
          if (head_op != 2'b00) begin
            x_next     = head_x;
            y_next     = head_y;
            ctrl_next  = head_op;
            state_next = S_ISSUE;
          end
        end
      end

      // ALU registers its result at the closing edge of this cycle.
      S_ISSUE: begin
        state_next = S_CAPTURE;
      end

      // Pins stay put, so the ALU re-executing here reproduces the result.
      S_CAPTURE: begin
        res_data_next  = output_result;
        res_valid_next = 1'b1;
        ctrl_next      = 2'b00;
        state_next     = S_HOLD;
      end

      S_HOLD: begin
        if (res_ready) begin
          res_valid_next = 1'b0;
          state_next     = S_IDLE;
          // Pop on the handshake edge so back-to-back commands skip IDLE.
          if (!fifo_empty) begin
            pop = 1'b1;
            if (head_op != 2'b00) begin
              x_next     = head_x;
              y_next     = head_y;
              ctrl_next  = head_op;
              state_next = S_ISSUE;
            end
          end
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

`ifdef ALU_SEQ_STATS_EN
  // Completed result handshakes, wrapping at 8 bits.
  logic [7:0] ops_done_reg;

  assign ops_done = ops_done_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ops_done_reg <= 8'd0;
    end else if (res_valid_reg && res_ready) begin
      ops_done_reg <= ops_done_reg + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Testbench for alu_cmd_sequencer. Contains a behavioural model of the
// registered 4-bit ALU; expected results are hand-computed constants pushed
// into a scoreboard queue and checked by an independent result monitor.
module tb_alu_cmd_sequencer;

  localparam int WIDTH = 4;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_x;
  logic [WIDTH-1:0] cmd_y;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] input_x;
  logic [WIDTH-1:0] input_y;
  logic [1:0]       control_signal;
  logic [WIDTH-1:0] output_result;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;
  logic [$clog2(DEPTH):0] fifo_count;
`ifdef ALU_SEQ_STATS_EN
  logic [7:0]       ops_done;
`endif

  alu_cmd_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_x          (cmd_x),
    .cmd_y          (cmd_y),
    .cmd_op         (cmd_op),
    .input_x        (input_x),
    .input_y        (input_y),
    .control_signal (control_signal),
    .output_result  (output_result),
    .res_valid      (res_valid),
    .res_ready      (res_ready),
    .res_data       (res_data),
    .fifo_count     (fifo_count)
`ifdef ALU_SEQ_STATS_EN
    ,
    .ops_done       (ops_done)
`endif
  );

  always #5 clk = ~clk;

  // Registered ALU model: 01 add, 10 sub, otherwise hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      output_result <= '0;
    end else begin
      case (control_signal)
        2'b01:   output_result <= input_x + input_y;
        2'b10:   output_result <= input_x - input_y;
        default: output_result <= output_result;
      endcase
    end
  end

  int tests = 0;
  int fails = 0;
  int res_cnt = 0;
  int cycle = 0;
  int last_res_cycle = 0;
  int last_gap = 0;
  logic [WIDTH-1:0] exp_q[$];

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Result monitor: sampled on the falling edge, i.e. the values that the
  // next rising edge will see as a handshake.
  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) begin
      logic [WIDTH-1:0] e;
      res_cnt++;
      last_gap = cycle - last_res_cycle;
      last_res_cycle = cycle;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_result: got %b, required no result", res_data);
      end else begin
        e = exp_q.pop_front();
        $display("[TB] result %b expected %b", res_data, e);
        check("res_data", 32'(res_data), 32'(e));
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; leaves just after the accepting edge.
  task automatic push_cmd(input logic [3:0] x, input logic [3:0] y,
                          input logic [1:0] op, input logic [3:0] e);
    int n = 0;
    while (!cmd_ready && n < 300) begin
      sync();
      n++;
    end
    if (!cmd_ready) begin
      tests++;
      fails++;
      $display("FAIL push_timeout: cmd_ready stayed 0, required 1");
    end else begin
      cmd_valid = 1'b1;
      cmd_x     = x;
      cmd_y     = y;
      cmd_op    = op;
      if (op != 2'b00) exp_q.push_back(e);
      sync();
      cmd_valid = 1'b0;
    end
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check({name, "_drain_pending"}, 32'(exp_q.size()), 0);
    exp_q.delete();
    repeat (8) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    int acc;
    cmd_valid = 1'b0;
    cmd_x     = '0;
    cmd_y     = '0;
    cmd_op    = 2'b00;
    res_ready = 1'b1;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 1);
    check("rst_fifo_count", 32'(fifo_count), 0);
    check("rst_res_valid", 32'(res_valid), 0);
    check("rst_res_data", 32'(res_data), 0);
    check("rst_control", 32'(control_signal), 0);
    check("rst_input_x", 32'(input_x), 0);
    check("rst_input_y", 32'(input_y), 0);
`ifdef ALU_SEQ_STATS_EN
    check("rst_ops_done", 32'(ops_done), 0);
`endif
    rst = 1'b0;
    sync();

    // Add with exact timing: accept E0, pins E1, ALU E2, res_valid E3
    cmd_valid = 1'b1;
    cmd_x     = 4'b1010;
    cmd_y     = 4'b0101;
    cmd_op    = 2'b01;
    exp_q.push_back(4'b1111);
    sync();                      // E0
    cmd_valid = 1'b0;
    @(negedge clk);
    check("add_count_after_e0", 32'(fifo_count), 1);
    @(negedge clk);              // after E1
    check("add_control_e1", 32'(control_signal), 1);
    check("add_input_x_e1", 32'(input_x), 32'h0000000a);
    check("add_input_y_e1", 32'(input_y), 32'h00000005);
    check("add_count_e1", 32'(fifo_count), 0);
    @(negedge clk);              // after E2
    check("add_res_valid_e2", 32'(res_valid), 0);
    @(negedge clk);              // after E3
    check("add_res_valid_e3", 32'(res_valid), 1);
    wait_drain("add");
    sync();

    // Back-to-back subtracts, 3-cycle result spacing
    push_cmd(4'b1100, 4'b0110, 2'b10, 4'b0110);
    push_cmd(4'b0111, 4'b0011, 2'b10, 4'b0100);
    wait_drain("sub");
    check("sub_result_gap", 32'(last_gap), 3);
    sync();

    // Wrap and drop: exactly two results
    r0 = res_cnt;
    push_cmd(4'b1111, 4'b0001, 2'b01, 4'b0000);
    push_cmd(4'b0000, 4'b0000, 2'b00, 4'b0000);
    push_cmd(4'b0011, 4'b0001, 2'b10, 4'b0010);
    wait_drain("drop");
    check("drop_result_count", 32'(res_cnt - r0), 2);
    sync();

    // Backpressure: 1 in flight + 4 queued, then not ready
    res_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      if (cmd_ready) begin
        cmd_valid = 1'b1;
        cmd_x     = 4'(i + 1);
        cmd_y     = 4'd2;
        cmd_op    = 2'b01;
        exp_q.push_back(4'(i + 3));
        acc++;
      end else begin
        cmd_valid = 1'b0;
      end
      sync();
    end
    cmd_valid = 1'b0;
    check("bp_accepted", 32'(acc), 5);
    check("bp_fifo_count", 32'(fifo_count), 4);
    check("bp_cmd_ready", 32'(cmd_ready), 0);
    check("bp_res_valid", 32'(res_valid), 1);
    res_ready = 1'b1;
    wait_drain("bp");
    check("bp_cmd_ready_after", 32'(cmd_ready), 1);
    check("bp_fifo_count_after", 32'(fifo_count), 0);
    sync();

    // Reset during CAPTURE with 3 commands queued
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_cmd(4'(i), 4'd1, 2'b01, 4'(i + 1));
    res_ready = 1'b1;
    @(posedge clk);              // handshake of first result, pop -> ISSUE
    @(posedge clk);              // -> CAPTURE
    @(negedge clk);
    check("mid_fifo_count", 32'(fifo_count), 3);
    check("mid_res_valid", 32'(res_valid), 0);
    rst = 1'b1;
    #1;
    check("mid_rst_cmd_ready", 32'(cmd_ready), 1);
    check("mid_rst_fifo_count", 32'(fifo_count), 0);
    check("mid_rst_control", 32'(control_signal), 0);
    check("mid_rst_input_x", 32'(input_x), 0);
    check("mid_rst_res_valid", 32'(res_valid), 0);
    check("mid_rst_res_data", 32'(res_data), 0);
    exp_q.delete();
    r0 = res_cnt;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("mid_no_result_after", 32'(res_cnt - r0), 0);
    check("mid_fifo_empty_after", 32'(fifo_count), 0);

`ifdef ALU_SEQ_STATS_EN
    // 257 completed handshakes wrap the counter to 1
    sync();
    for (int i = 0; i < 257; i++) push_cmd(4'(i), 4'd1, 2'b01, 4'(i + 1));
    wait_drain("stats");
    check("stats_ops_done", 32'(ops_done), 1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
